// File: rtl/fpu_csr_queue.sv
// fpu_csr_queue: memory-mapped FPU front end with queued commands and results.
// Ports:
//   Clk, RstN                 clock, asynchronous active-low reset
//   ChipSelect/Write/Read     bus strobes, Address selects one of eight registers
//   WriteData / ReadData      bus data in / registered bus data out
//   a_operand/b_operand/Operation, fpu_valid, fpu_ready   command handshake to the FPU
//   fpu_res_valid, FPU_Output, Exception/Overflow/Underflow   result pulse from the FPU
//   Irq                       registered interrupt
module fpu_csr_queue #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4,
   parameter int DEPTH  = 4
) (
   input  logic              Clk,
   input  logic              RstN,
   input  logic              ChipSelect,
   input  logic              Write,
   input  logic              Read,
   input  logic [2:0]        Address,
   input  logic [DATA_W-1:0] WriteData,
   output logic [DATA_W-1:0] ReadData,
   output logic [DATA_W-1:0] a_operand,
   output logic [DATA_W-1:0] b_operand,
   output logic [OP_W-1:0]   Operation,
   output logic              fpu_valid,
   input  logic              fpu_ready,
   input  logic              fpu_res_valid,
   input  logic [DATA_W-1:0] FPU_Output,
   input  logic              Exception,
   input  logic              Overflow,
   input  logic              Underflow,
   output logic              Irq
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = 2*DATA_W + OP_W;
   localparam int RW = DATA_W + 3;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
   state_t r_state, w_state_n;

   logic [CW-1:0]     r_cmd_mem [DEPTH];
   logic [RW-1:0]     r_res_mem [DEPTH];
   logic [AW-1:0]     r_cmd_wp, r_cmd_rp, r_res_wp, r_res_rp;
   logic [AW:0]       r_cmd_cnt, r_res_cnt;
   logic [DATA_W-1:0] r_a, r_b;
   logic [OP_W-1:0]   r_op;
   logic              r_irq_en, r_cmd_ovf, r_res_unf, r_discard;

   logic              w_wr, w_rd, w_cmd_wr, w_cmd_push, w_cmd_ovf_set, w_flush;
   logic              w_issue, w_res_rd, w_res_pop, w_res_unf_set, w_res_push;
   logic              w_flags_wr;
   logic [CW-1:0]     w_cmd_head;
   logic [RW-1:0]     w_res_head;
   logic [DATA_W-1:0] w_status, w_rd_val;

   assign w_wr          = ChipSelect & Write;
   assign w_rd          = ChipSelect & Read;
   assign w_cmd_wr      = w_wr & (Address == 3'd3);
   // Fullness uses the count before any same-cycle issue pop.
   assign w_cmd_push    = w_cmd_wr & (r_cmd_cnt != FULL);
   assign w_cmd_ovf_set = w_cmd_wr & (r_cmd_cnt == FULL);
   assign w_flush       = w_wr & (Address == 3'd6) & WriteData[1];
   assign w_flags_wr    = w_wr & (Address == 3'd7);
   // Issue only when a result slot is free, so the later push can never overflow.
   assign w_issue       = (r_state == S_IDLE) & (r_cmd_cnt != '0) & (r_res_cnt != FULL);
   assign w_res_rd      = w_rd & (Address == 3'd4);
   assign w_res_pop     = w_res_rd & (r_res_cnt != '0);
   assign w_res_unf_set = w_res_rd & (r_res_cnt == '0);
   assign w_res_push    = (r_state == S_WAIT) & fpu_res_valid & ~r_discard;
   assign w_cmd_head    = r_cmd_mem[r_cmd_rp];
   assign w_res_head    = r_res_mem[r_res_rp];
   assign fpu_valid     = (r_state == S_ISSUE);

   always_comb begin
      w_state_n = r_state;
      case (r_state)
         S_IDLE:  w_state_n = w_issue ? S_ISSUE : S_IDLE;
         S_ISSUE: w_state_n = fpu_ready ? S_WAIT : S_ISSUE;
         S_WAIT:  w_state_n = fpu_res_valid ? S_IDLE : S_WAIT;
         default: w_state_n = S_IDLE;
      endcase
   end

   always_comb begin
      w_status        = '0;
      w_status[0]     = (r_cmd_cnt == '0);
      w_status[1]     = (r_cmd_cnt == FULL);
      w_status[2]     = (r_res_cnt == '0);
      w_status[3]     = (r_res_cnt == FULL);
      w_status[4]     = (r_state != S_IDLE);
      w_status[5]     = r_cmd_ovf;
      w_status[6]     = r_res_unf;
      w_status[9:7]   = (r_res_cnt != '0) ? w_res_head[RW-1:DATA_W] : 3'b000;
      w_status[23:16] = 8'(r_cmd_cnt);
      w_status[31:24] = 8'(r_res_cnt);
      w_rd_val        = '0;
      case (Address)
         3'd0:    w_rd_val = r_a;
         3'd1:    w_rd_val = r_b;
         3'd2:    w_rd_val = DATA_W'(r_op);
         3'd4:    w_rd_val = (r_res_cnt != '0) ? w_res_head[DATA_W-1:0] : '0;
         3'd5:    w_rd_val = w_status;
         3'd6:    w_rd_val = DATA_W'(r_irq_en);
         3'd7:    w_rd_val = DATA_W'({r_res_unf, r_cmd_ovf});
         default: w_rd_val = '0;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (w_cmd_push)
         r_cmd_mem[r_cmd_wp] <= {r_a, r_b, r_op};
      if (w_res_push)
         r_res_mem[r_res_wp] <= {Underflow, Overflow, Exception, FPU_Output};
   end

   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         r_state   <= S_IDLE;
         r_cmd_wp  <= '0;
         r_cmd_rp  <= '0;
         r_res_wp  <= '0;
         r_res_rp  <= '0;
         r_cmd_cnt <= '0;
         r_res_cnt <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_op      <= '0;
         r_irq_en  <= 1'b0;
         r_cmd_ovf <= 1'b0;
         r_res_unf <= 1'b0;
         r_discard <= 1'b0;
         ReadData  <= '0;
         a_operand <= '0;
         b_operand <= '0;
         Operation <= '0;
         Irq       <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_cmd_wp  <= w_flush ? '0 : r_cmd_wp + AW'(w_cmd_push);
         r_cmd_rp  <= w_flush ? '0 : r_cmd_rp + AW'(w_issue);
         r_res_wp  <= w_flush ? '0 : r_res_wp + AW'(w_res_push);
         r_res_rp  <= w_flush ? '0 : r_res_rp + AW'(w_res_pop);
         r_cmd_cnt <= w_flush ? '0 : r_cmd_cnt + (AW+1)'(w_cmd_push) - (AW+1)'(w_issue);
         r_res_cnt <= w_flush ? '0 : r_res_cnt + (AW+1)'(w_res_push) - (AW+1)'(w_res_pop);
         if (w_wr && Address == 3'd0)
            r_a <= WriteData;
         if (w_wr && Address == 3'd1)
            r_b <= WriteData;
         if (w_wr && Address == 3'd2)
            r_op <= WriteData[OP_W-1:0];
         if (w_wr && Address == 3'd6)
            r_irq_en <= WriteData[0];
         // A new event wins over a same-cycle clear.
         r_cmd_ovf <= w_cmd_ovf_set | (r_cmd_ovf & ~(w_flags_wr & WriteData[0]));
         r_res_unf <= w_res_unf_set | (r_res_unf & ~(w_flags_wr & WriteData[1]));
         // A flush marks any command already handed to the FPU so its result is dropped.
         r_discard <= (w_state_n == S_IDLE) ? 1'b0 : (r_discard | w_flush);
         if (w_rd)
            ReadData <= w_rd_val;
         if (w_issue)
            {a_operand, b_operand, Operation} <= w_cmd_head;
         Irq <= r_irq_en & ((r_res_cnt != '0) | r_cmd_ovf | r_res_unf);
      end
   end
endmodule
